booth_radix4_multiplier: RTL and testbench

Radix-4 (modified Booth) partial-product generator for the 32×32 multiply datapath. Recodes multiplier B into 17 Booth digits and produces 17 registered, pre-shifted, 64-bit two's-complement partial products of multiplicand A. Supports signed and unsigned operands. Feeds the downstream compression tree; the 64-bit sum of all partial products equals A×B mod 2^64.

---
 rtl/booth_pkg.sv | 34 +++
 rtl/booth_pp_row.sv | 38 +++
 rtl/booth_radix4_multiplier.sv | 115 +++++++++++
 tb/tb_booth_radix4_multiplier.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared widths, Booth digit type and the radix-4 recode function for the
// 32x32 Booth partial-product generator.
package booth_pkg;

    localparam int DATA_W  = 32;
    localparam int PP_W    = 64;
    localparam int NUM_PP  = 17;
    localparam int A_EXT_W = DATA_W + 1;
    localparam int B_EXT_W = DATA_W + 2;
    localparam int ROW_W   = 5;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } booth_digit_e;

    // Group bits are {b[2i+1], b[2i], b[2i-1]}.
    function automatic booth_digit_e booth_recode(input logic [2:0] grp);
        booth_digit_e d;
        case (grp)
            3'b000, 3'b111: d = ZERO;
            3'b001, 3'b010: d = POS1;
            3'b011:         d = POS2;
            3'b100:         d = NEG2;
            3'b101, 3'b110: d = NEG1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_pp_row.sv
// One Booth partial-product row: recodes a 3-bit group and forms
// sign_extend(d * A_ext) << 2*row as a full 64-bit two's-complement value.
module booth_pp_row
    import booth_pkg::*;
(
    input  logic [2:0]         i_group,
    input  logic [A_EXT_W-1:0] i_a_ext,
    input  logic [ROW_W-1:0]   i_row,
    output logic [PP_W-1:0]    o_pp
);

    booth_digit_e    w_digit;
    logic [PP_W-1:0] w_a_sx;
    logic [PP_W-1:0] w_unshifted;

    always_comb begin
        w_digit = booth_recode(i_group);
        w_a_sx  = {{(PP_W - A_EXT_W){i_a_ext[A_EXT_W-1]}}, i_a_ext};
    end

    // Negation is folded in here so downstream sees a complete value, no carry-in bit.
    always_comb begin
        w_unshifted = '0;
        case (w_digit)
            ZERO:    w_unshifted = '0;
            POS1:    w_unshifted = w_a_sx;
            POS2:    w_unshifted = w_a_sx << 1;
            NEG1:    w_unshifted = ~w_a_sx + 64'd1;
            NEG2:    w_unshifted = ~(w_a_sx << 1) + 64'd1;
            default: w_unshifted = '0;
        endcase
    end

    always_comb begin
        o_pp = w_unshifted << {i_row, 1'b0};
    end

endmodule

// File: rtl/booth_radix4_multiplier.sv
// Radix-4 Booth partial-product generator: 17 registered, pre-shifted 64-bit PPs
// whose sum is A*B mod 2^64. Optional `product` output under BOOTH_PRODUCT_EN.
module booth_radix4_multiplier
    import booth_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              alu_signed,
    input  logic              in_valid,
`ifdef BOOTH_PRODUCT_EN
    output logic [PP_W-1:0]   product,
`endif
    output logic              out_valid,
    output logic [PP_W-1:0]   PP0,
    output logic [PP_W-1:0]   PP1,
    output logic [PP_W-1:0]   PP2,
    output logic [PP_W-1:0]   PP3,
    output logic [PP_W-1:0]   PP4,
    output logic [PP_W-1:0]   PP5,
    output logic [PP_W-1:0]   PP6,
    output logic [PP_W-1:0]   PP7,
    output logic [PP_W-1:0]   PP8,
    output logic [PP_W-1:0]   PP9,
    output logic [PP_W-1:0]   PP10,
    output logic [PP_W-1:0]   PP11,
    output logic [PP_W-1:0]   PP12,
    output logic [PP_W-1:0]   PP13,
    output logic [PP_W-1:0]   PP14,
    output logic [PP_W-1:0]   PP15,
    output logic [PP_W-1:0]   PP16
);

    logic [A_EXT_W-1:0] w_a_ext;
    logic [B_EXT_W-1:0] w_b_ext;
    logic [B_EXT_W:0]   w_b_pad;
    logic [PP_W-1:0]    w_pp [NUM_PP];
    logic [PP_W-1:0]    r_pp [NUM_PP];
    logic               r_out_valid;

    // Unsigned operands get zero extension, which makes group 16 = 001 when B[31]=1.
    always_comb begin
        w_a_ext = {alu_signed & A[DATA_W-1], A};
        w_b_ext = {{2{alu_signed & B[DATA_W-1]}}, B};
        w_b_pad = {w_b_ext, 1'b0};
    end

    for (genvar gi = 0; gi < NUM_PP; gi++) begin : g_row
        booth_pp_row u_row (
            .i_group (w_b_pad[2*gi+2 -: 3]),
            .i_a_ext (w_a_ext),
            .i_row   (ROW_W'(gi)),
            .o_pp    (w_pp[gi])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_PP; k++) begin
                r_pp[k] <= '0;
            end
            r_out_valid <= 1'b0;
        end else begin
            if (in_valid) begin
                for (int k = 0; k < NUM_PP; k++) begin
                    r_pp[k] <= w_pp[k];
                end
            end
            r_out_valid <= in_valid;
        end
    end

`ifdef BOOTH_PRODUCT_EN
    logic [PP_W-1:0] w_pp_sum;
    logic [PP_W-1:0] r_product;

    always_comb begin
        w_pp_sum = '0;
        for (int k = 0; k < NUM_PP; k++) begin
            w_pp_sum = w_pp_sum + w_pp[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_product <= '0;
        end else if (in_valid) begin
            r_product <= w_pp_sum;
        end
    end

    assign product = r_product;
`endif

    assign out_valid = r_out_valid;
    assign PP0  = r_pp[0];
    assign PP1  = r_pp[1];
    assign PP2  = r_pp[2];
    assign PP3  = r_pp[3];
    assign PP4  = r_pp[4];
    assign PP5  = r_pp[5];
    assign PP6  = r_pp[6];
    assign PP7  = r_pp[7];
    assign PP8  = r_pp[8];
    assign PP9  = r_pp[9];
    assign PP10 = r_pp[10];
    assign PP11 = r_pp[11];
    assign PP12 = r_pp[12];
    assign PP13 = r_pp[13];
    assign PP14 = r_pp[14];
    assign PP15 = r_pp[15];
    assign PP16 = r_pp[16];

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Bench for booth_radix4_multiplier: directed PP vectors, hold/reset behaviour
// and back-to-back random operands checked against a 64-bit reference product.
module tb_booth_radix4_multiplier;

    logic        clk;
    logic        rst_n;
    logic [31:0] A;
    logic [31:0] B;
    logic        alu_signed;
    logic        in_valid;
    logic        out_valid;
    logic [63:0] PP0, PP1, PP2, PP3, PP4, PP5, PP6, PP7, PP8;
    logic [63:0] PP9, PP10, PP11, PP12, PP13, PP14, PP15, PP16;
`ifdef BOOTH_PRODUCT_EN
    logic [63:0] product;
`endif

    logic [63:0] pp [17];
    logic [63:0] pp_sum;
    logic [63:0] pp_or;
    logic [63:0] exp_q[$];

    int n_checks;
    int n_pass;

    booth_radix4_multiplier dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .A          (A),
        .B          (B),
        .alu_signed (alu_signed),
        .in_valid   (in_valid),
`ifdef BOOTH_PRODUCT_EN
        .product    (product),
`endif
        .out_valid  (out_valid),
        .PP0 (PP0),   .PP1 (PP1),   .PP2 (PP2),   .PP3 (PP3),
        .PP4 (PP4),   .PP5 (PP5),   .PP6 (PP6),   .PP7 (PP7),
        .PP8 (PP8),   .PP9 (PP9),   .PP10 (PP10), .PP11 (PP11),
        .PP12 (PP12), .PP13 (PP13), .PP14 (PP14), .PP15 (PP15),
        .PP16 (PP16)
    );

    assign pp[0]  = PP0;  assign pp[1]  = PP1;  assign pp[2]  = PP2;
    assign pp[3]  = PP3;  assign pp[4]  = PP4;  assign pp[5]  = PP5;
    assign pp[6]  = PP6;  assign pp[7]  = PP7;  assign pp[8]  = PP8;
    assign pp[9]  = PP9;  assign pp[10] = PP10; assign pp[11] = PP11;
    assign pp[12] = PP12; assign pp[13] = PP13; assign pp[14] = PP14;
    assign pp[15] = PP15; assign pp[16] = PP16;

    always_comb begin
        pp_sum = '0;
        pp_or  = '0;
        for (int k = 0; k < 17; k++) begin
            pp_sum = pp_sum + pp[k];
            pp_or  = pp_or | pp[k];
        end
    end

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_mult(input logic [31:0] a, input logic [31:0] b,
                                             input logic s);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = s ? {{32{a[31]}}, a} : {32'b0, a};
        eb = s ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [63:0] exp);
        @(negedge clk);
        A          = a;
        B          = b;
        alu_signed = s;
        in_valid   = 1'b1;
        exp_q.push_back(exp);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        A        = $urandom;
        B        = $urandom;
    endtask

    task automatic after_capture();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("pp_sum", pp_sum, e);
`ifdef BOOTH_PRODUCT_EN
                chk("product", product, e);
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_checks   = 0;
        n_pass     = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        A          = '0;
        B          = '0;
        alu_signed = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_pps", pp_or, 64'd0);
`ifdef BOOTH_PRODUCT_EN
        chk("reset_product", product, 64'd0);
`endif
        rst_n = 1'b1;

        // Unsigned 5*3
        drive(32'd5, 32'd3, 1'b0, 64'hF);
        after_capture();
        chk("u53_valid", 64'(out_valid), 64'd1);
        chk("u53_pp0", PP0, 64'hFFFF_FFFF_FFFF_FFFB);
        chk("u53_pp1", PP1, 64'h14);
        chk("u53_rest", pp_or & ~(PP0 | PP1), 64'd0);
        chk("u53_pp16", PP16, 64'd0);

        // Hold for three idle cycles
        for (int h = 0; h < 3; h++) begin
            idle();
            after_capture();
            chk("hold_valid", 64'(out_valid), 64'd0);
            chk("hold_pp0", PP0, 64'hFFFF_FFFF_FFFF_FFFB);
            chk("hold_pp1", PP1, 64'h14);
        end

        // Signed -5*3
        drive(32'hFFFF_FFFB, 32'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
        after_capture();
        chk("s53_pp0", PP0, 64'h5);
        chk("s53_pp1", PP1, 64'hFFFF_FFFF_FFFF_FFEC);
        chk("s53_rest", pp_or & ~(PP0 | PP1), 64'd0);

        // All ones, unsigned then signed
        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        after_capture();
        chk("uff_pp16", PP16, 64'hFFFF_FFFF_0000_0000);
        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h1);
        after_capture();
        chk("sff_pp16", PP16, 64'd0);

        // Signed extremes, back to back
        drive(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        drive(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000);

        // Random back-to-back traffic with occasional bubbles and one mid-stream reset
        for (int i = 0; i < 10000; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic        s;
            a = pick_operand();
            b = pick_operand();
            s = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 31) == 0) begin
                idle();
            end
            drive(a, b, s, ref_mult(a, b, s));
            if (i == 5000) begin
                @(posedge clk);
                #2;
                rst_n = 1'b0;
                #1;
                chk("midrst_valid", 64'(out_valid), 64'd0);
                chk("midrst_pps", pp_or, 64'd0);
`ifdef BOOTH_PRODUCT_EN
                chk("midrst_product", product, 64'd0);
`endif
                exp_q.delete();
                in_valid = 1'b0;
                @(negedge clk);
                chk("midrst_hold_valid", 64'(out_valid), 64'd0);
                chk("midrst_hold_pps", pp_or, 64'd0);
                rst_n = 1'b1;
            end
        end

        idle();
        repeat (3) @(negedge clk);
        chk("drain_queue", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
